fc_argmax_accum: RTL and testbench
==================================

Name: fc_argmax_accum

Overview:
- Fully-connected output layer. Sits directly downstream of the pooling-2 output memory read counter.
- Consumes the 192 pooled features (12 channels x 4x4) in the order that counter produces them (channel*16 + addr).
- Multiply-accumulates each feature against one packed 10-class weight row from a weight ROM, then adds a bias row.
- Selects the winning digit by sequential argmax and holds the result for the host interface.

Parameters:
N_FEAT, 192, features per image; also the ROM address of the bias row
N_CLASS, 10, output classes
DW, 16, feature width, signed Q8.8
WW, 16, weight/bias width, signed Q8.8
AW, 32, accumulator width, signed
FRAC, 8, fractional bits removed from each product

Ports:
clk  in  1  clock; all registers update on falling edge
reset  in  1  reset, asynchronous, active-high
start  in  1  begin new image; sampled only in IDLE or DONE
feat_valid  in  1  feat_data valid this edge
feat_data  in  DW  pooled feature, signed
w_addr  out  8  weight ROM row address, equal to internal idx
w_data  in  N_CLASS*WW  packed weight row; class j at bits [j*WW +: WW]
busy  out  1  high in ACCUM, DRAIN, BIAS, ARGMAX
done  out  1  result valid, held
digit  out  4  winning class index
score  out  AW  winning accumulator value

Behaviour:
- Reset values: all outputs 0, idx 0, pend 0, all accumulators 0, state IDLE.
- Reset mid-operation aborts immediately; no partial state survives.
- ROM contract: w_data reflects the w_addr value registered at the previous active edge (one-cycle ROM).
- States:
  - IDLE: start -> clear acc[0..9], idx=0, pend=0, done=0, go to ACCUM.
  - ACCUM: on feat_valid, latch f_q=feat_data, set pend=1, idx++. Without feat_valid, pend=0 (gaps allowed, any length). When feature index N_FEAT-1 is accepted, idx becomes N_FEAT -> DRAIN.
  - MAC (any state): when pend=1, for every j, acc[j] += sign_ext_AW((f_q * w_j) >>> FRAC).
    - Product is full-precision DW+WW signed; shift is arithmetic; addition wraps, no saturation.
    - Sizing guarantees no overflow for legal Q8.8 inputs.
  - Back-to-back feat_valid sustains one MAC per edge.
  - DRAIN: one edge; performs the last MAC; pend=0; ROM now addressing the bias row -> BIAS.
  - BIAS: acc[j] += sign_ext_AW(bias_j), where bias_j is taken from w_data (bias row), no shift -> ARGMAX with j=0.
  - ARGMAX: one class per edge, 10 edges.
    - j=0 loads best=acc[0], bidx=0.
    - j>0 replaces only if acc[j] > best (signed, strict), so ties resolve to the lowest index.
    - On the j=9 edge: digit=bidx, score=best, done=1 -> DONE.
  - DONE: outputs held; busy=0; start -> done=0, re-enter ACCUM with cleared state.
- Latency: last feature accepted at edge E -> done high after edge E+12.
- feat_valid outside ACCUM is ignored; idx never exceeds N_FEAT.
- start while busy is ignored.
- start coincident with the final ARGMAX edge is ignored.
- w_addr = idx at all times; idx is 0 in IDLE and DONE.

Test Plan:
- Features all 0x0000; bias row class 7 = 0x0100, others 0x0000 -> digit=7, score=256, done after edge E+12, busy low.
- Features all 0x0100 (1.0); class 3 weights 0x0001, all other weights and biases 0 -> acc3 = 192 -> digit=3, score=192.
- Class 2 and class 5 weights both 0x0001 for all rows, others 0, features 0x0100 -> tie at 192 -> digit=2.
- Negative values: features 0xFF00 (-1.0), all weights 0x0001 except class 4 = 0xFFFF, biases 0.
  - Per-feature product for class 4 = +1, all other classes = -1.
  - Required: digit=4, score=192, other accumulators = -192.
- Feature stream with random 0-5 cycle gaps between feat_valid, data as in the class-3 test -> identical result.
  - w_addr tracks the accepted-feature count.
  - Extra feat_valid after the 192nd feature has no effect.
- Assert reset after 100 features, release, pulse start, stream the full 192 from the class-3 test -> digit=3, score=192 (no residue).
  - A start pulsed during ARGMAX is ignored.

Source files
------------

// File: rtl/fc_argmax_accum_if.sv
// rtl/fc_argmax_accum_if.sv - feature stream, weight ROM and result signals of fc_argmax_accum
//
// Signals:
//   start       begin a new image (master -> slave)
//   feat_valid  feat_data valid this edge (master -> slave)
//   feat_data   pooled feature, signed Q8.8 (master -> slave)
//   w_addr      weight ROM row address (slave -> master)
//   w_data      packed weight/bias row, class j at [j*WW +: WW] (master -> slave)
//   busy        image in progress (slave -> master)
//   done        result valid, held (slave -> master)
//   digit       winning class index (slave -> master)
//   score       winning accumulator value (slave -> master)
interface fc_argmax_accum_if #(
    parameter int DW      = 16,
    parameter int WW      = 16,
    parameter int N_CLASS = 10,
    parameter int AW      = 32
);
    logic                    start;
    logic                    feat_valid;
    logic [DW-1:0]           feat_data;
    logic [7:0]              w_addr;
    logic [N_CLASS*WW-1:0]   w_data;
    logic                    busy;
    logic                    done;
    logic [3:0]              digit;
    logic [AW-1:0]           score;

    modport master (
        output start, feat_valid, feat_data, w_data,
        input  w_addr, busy, done, digit, score
    );

    modport slave (
        input  start, feat_valid, feat_data, w_data,
        output w_addr, busy, done, digit, score
    );
endinterface

// File: rtl/fc_argmax_accum.sv
// rtl/fc_argmax_accum.sv - fully-connected output layer with bias add and sequential argmax
//
// Ports:
//   clk    clock; all registers update on the falling edge
//   reset  asynchronous, active-high
//   bus    fc_argmax_accum_if.slave: start, feat_valid/feat_data in,
//          w_addr out / w_data in (one-cycle weight ROM), busy/done/digit/score out
//
// Features arrive in pooling-counter order (channel*16 + addr). Each accepted
// feature is latched and multiplied one edge later against the ROM row that
// the ROM registered on the acceptance edge. Row N_FEAT holds the biases.
module fc_argmax_accum #(
    parameter int N_FEAT  = 192,
    parameter int N_CLASS = 10,
    parameter int DW      = 16,
    parameter int WW      = 16,
    parameter int AW      = 32,
    parameter int FRAC    = 8
) (
    input logic              clk,
    input logic              reset,
    fc_argmax_accum_if.slave bus
);
    localparam int PW = DW + WW;
    localparam logic [7:0] LAST_IDX = 8'(N_FEAT - 1);
    localparam logic [3:0] LAST_J   = 4'(N_CLASS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCUM  = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_BIAS   = 3'd3;
    localparam logic [2:0] S_ARGMAX = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]             state;
    logic [7:0]             idx;
    logic                   pend;
    logic signed [DW-1:0]   f_q;
    logic signed [AW-1:0]   acc [N_CLASS];
    logic signed [AW-1:0]   best;
    logic [3:0]             bidx;
    logic [3:0]             j;
    logic                   done_q;
    logic [3:0]             digit_q;
    logic [AW-1:0]          score_q;

    logic signed [AW-1:0]   mac_term  [N_CLASS];
    logic signed [AW-1:0]   bias_term [N_CLASS];
    logic signed [AW-1:0]   cand;
    logic                   cand_gt;

    // Full-precision signed product, arithmetic shift back to Q8.8, sign-extended.
    function automatic logic signed [AW-1:0] mac_fn(
        input logic signed [DW-1:0] f,
        input logic signed [WW-1:0] w
    );
        logic signed [PW-1:0] p;
        p = PW'(f) * PW'(w);
        return AW'(p >>> FRAC);
    endfunction

    always_comb begin
        for (int c = 0; c < N_CLASS; c++) begin
            mac_term[c]  = mac_fn(f_q, $signed(bus.w_data[c*WW +: WW]));
            bias_term[c] = AW'($signed(bus.w_data[c*WW +: WW]));
        end
    end

    assign cand    = acc[j];
    assign cand_gt = cand > best;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            pend    <= 1'b0;
            f_q     <= '0;
            best    <= '0;
            bidx    <= '0;
            j       <= '0;
            done_q  <= 1'b0;
            digit_q <= '0;
            score_q <= '0;
            for (int c = 0; c < N_CLASS; c++) acc[c] <= '0;
        end else begin
            // The MAC trails acceptance by one edge so it pairs f_q with the
            // ROM row registered on the acceptance edge; it runs in any state.
            if (pend) begin
                for (int c = 0; c < N_CLASS; c++) acc[c] <= acc[c] + mac_term[c];
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        for (int c = 0; c < N_CLASS; c++) acc[c] <= '0;
                        idx    <= '0;
                        pend   <= 1'b0;
                        done_q <= 1'b0;
                        state  <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (bus.feat_valid) begin
                        f_q  <= $signed(bus.feat_data);
                        pend <= 1'b1;
                        idx  <= idx + 8'd1;
                        if (idx == LAST_IDX) state <= S_DRAIN;
                    end else begin
                        pend <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // idx already equals N_FEAT, so the ROM registers the bias row here.
                    pend  <= 1'b0;
                    state <= S_BIAS;
                end
                S_BIAS: begin
                    for (int c = 0; c < N_CLASS; c++) acc[c] <= acc[c] + bias_term[c];
                    idx   <= '0;
                    j     <= '0;
                    state <= S_ARGMAX;
                end
                S_ARGMAX: begin
                    // Strict greater-than keeps the lowest index on ties.
                    if (j == 4'd0) begin
                        best <= cand;
                        bidx <= 4'd0;
                    end else if (cand_gt) begin
                        best <= cand;
                        bidx <= j;
                    end
                    if (j == LAST_J) begin
                        digit_q <= (j != 4'd0 && cand_gt) ? j : bidx;
                        score_q <= (j == 4'd0 || cand_gt) ? cand : best;
                        done_q  <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        j <= j + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.w_addr = idx;
    assign bus.busy   = (state == S_ACCUM) || (state == S_DRAIN) ||
                        (state == S_BIAS)  || (state == S_ARGMAX);
    assign bus.done   = done_q;
    assign bus.digit  = digit_q;
    assign bus.score  = score_q;
endmodule

// File: tb/tb_fc_argmax_accum.sv
// tb/tb_fc_argmax_accum.sv - directed self-checking bench for fc_argmax_accum
module tb_fc_argmax_accum;
    localparam int N_CLASS = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic signed [15:0] rom_w [N_CLASS];
    logic signed [15:0] rom_b [N_CLASS];

    fc_argmax_accum_if #(.DW(16), .WW(16), .N_CLASS(N_CLASS), .AW(32)) bus ();

    fc_argmax_accum #(
        .N_FEAT(192), .N_CLASS(N_CLASS), .DW(16), .WW(16), .AW(32), .FRAC(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // One-cycle ROM: registers the row for w_addr on each falling edge.
    always @(negedge clk) begin
        for (int c = 0; c < N_CLASS; c++)
            bus.w_data[c*16 +: 16] <= (bus.w_addr == 8'd192) ? rom_b[c] : rom_w[c];
    end

    task automatic clear_rom();
        for (int c = 0; c < N_CLASS; c++) begin
            rom_w[c] = 16'sh0000;
            rom_b[c] = 16'sh0000;
        end
    endtask

    task automatic run_image(input string name, input logic [15:0] fval, input int max_gap,
                             input bit extra_valid, input bit start_in_argmax,
                             input logic [3:0] exp_digit, input logic [31:0] exp_score);
        int gap;
        int lat;
        @(posedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s start: busy=%b done=%b required busy=1 done=0", name, bus.busy, bus.done);
        end
        for (int i = 0; i < 192; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            bus.feat_valid = 1'b0;
            repeat (gap) @(posedge clk);
            bus.feat_valid = 1'b1;
            bus.feat_data  = fval;
            @(posedge clk);
            if (max_gap > 0 || i == 191) begin
                checks++;
                if (bus.w_addr !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL %s w_addr after feature %0d: got %0d required %0d",
                             name, i, bus.w_addr, i + 1);
                end
            end
        end
        bus.feat_valid = extra_valid;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            if (start_in_argmax && lat == 5) bus.start = 1'b1;
            if (bus.done) break;
        end
        bus.start      = 1'b0;
        bus.feat_valid = 1'b0;
        checks++;
        if (lat !== 12) begin
            errors++;
            $display("FAIL %s latency: done after edge E+%0d required E+12", name, lat);
        end
        checks++;
        if (bus.digit !== exp_digit) begin
            errors++;
            $display("FAIL %s digit: got %0d required %0d", name, bus.digit, exp_digit);
        end
        checks++;
        if (bus.score !== exp_score) begin
            errors++;
            $display("FAIL %s score: got %0d required %0d", name, $signed(bus.score), $signed(exp_score));
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.w_addr !== 8'd0) begin
            errors++;
            $display("FAIL %s idle after done: busy=%b w_addr=%0d required busy=0 w_addr=0",
                     name, bus.busy, bus.w_addr);
        end
        if (start_in_argmax) begin
            @(posedge clk);
            checks++;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.digit !== exp_digit) begin
                errors++;
                $display("FAIL %s start during argmax: done=%b busy=%b digit=%0d required done=1 busy=0 digit=%0d",
                         name, bus.done, bus.busy, bus.digit, exp_digit);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset done/busy: done=%b busy=%b required 0/0", bus.done, bus.busy);
        end
        checks++;
        if (bus.digit !== 4'd0) begin
            errors++;
            $display("FAIL reset digit: got %0d required 0", bus.digit);
        end
        checks++;
        if (bus.score !== 32'd0) begin
            errors++;
            $display("FAIL reset score: got %0d required 0", bus.score);
        end
        checks++;
        if (bus.w_addr !== 8'd0) begin
            errors++;
            $display("FAIL reset w_addr: got %0d required 0", bus.w_addr);
        end
    endtask

    task automatic test_bias_only();
        clear_rom();
        rom_b[7] = 16'sh0100;
        run_image("bias_only", 16'h0000, 0, 1'b0, 1'b0, 4'd7, 32'd256);
    endtask

    task automatic test_single_class();
        clear_rom();
        rom_w[3] = 16'sh0001;
        run_image("class3", 16'h0100, 0, 1'b0, 1'b0, 4'd3, 32'd192);
    endtask

    task automatic test_tie();
        clear_rom();
        rom_w[2] = 16'sh0001;
        rom_w[5] = 16'sh0001;
        run_image("tie", 16'h0100, 0, 1'b0, 1'b0, 4'd2, 32'd192);
    endtask

    task automatic test_negative();
        clear_rom();
        for (int c = 0; c < N_CLASS; c++) rom_w[c] = 16'sh0001;
        rom_w[4] = -16'sh0001;
        run_image("negative", 16'hFF00, 0, 1'b0, 1'b0, 4'd4, 32'd192);
    endtask

    task automatic test_gaps();
        clear_rom();
        rom_w[3] = 16'sh0001;
        run_image("gaps", 16'h0100, 5, 1'b1, 1'b0, 4'd3, 32'd192);
    endtask

    task automatic test_reset_mid();
        clear_rom();
        rom_w[3] = 16'sh0001;
        @(posedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.feat_valid = 1'b1;
            bus.feat_data  = 16'h0100;
            @(posedge clk);
        end
        bus.feat_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.w_addr !== 8'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid abort: busy=%b w_addr=%0d done=%b required 0/0/0",
                     bus.busy, bus.w_addr, bus.done);
        end
        @(posedge clk);
        reset = 1'b0;
        run_image("after_reset", 16'h0100, 0, 1'b0, 1'b1, 4'd3, 32'd192);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.feat_valid = 1'b0;
        bus.feat_data  = 16'h0000;
        clear_rom();
        repeat (3) @(posedge clk);
        test_reset();
        reset = 1'b0;
        test_bias_only();
        test_single_class();
        test_tie();
        test_negative();
        test_gaps();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
